// File: rtl/hpm_overflow_ctrl_pkg.sv
// Shared constants and types for the HPM overflow controller (mhpmevent layout, LCOFI bit).
package hpm_overflow_ctrl_pkg;

  localparam int EVT_OF_BIT    = 63;
  localparam int EVT_MINH_BIT  = 62;
  localparam int EVT_SINH_BIT  = 61;
  localparam int EVT_UINH_BIT  = 60;
  localparam int LCOFI_MIP_BIT = 13;
  localparam int HPM_FIRST     = 3;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // Field order matches mhpmevent bits 63:60 so the struct packs straight into a CSR read.
  typedef struct packed {
    logic of;
    logic minh;
    logic sinh;
    logic uinh;
  } evt_cfg_t;

  function automatic logic mode_blocks(input logic [1:0] priv, input evt_cfg_t cfg);
    logic blk;
    blk = 1'b0;
    case (priv)
      PRIV_M:  blk = cfg.minh;
      PRIV_S:  blk = cfg.sinh;
      PRIV_U:  blk = cfg.uinh;
      default: blk = 1'b0;
    endcase
    return blk;
  endfunction

endpackage

// File: rtl/hpm_ovf_slice.sv
// One hpm counter's event config flops, mode filter, count enable and OF next-state logic.
module hpm_ovf_slice
  import hpm_overflow_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_event,
  input  logic       i_at_max,
  input  logic       i_inhibit,
  input  logic       i_stop,
  input  logic       i_freeze,
  input  logic [1:0] i_priv,
  input  logic       i_wr_en,
  input  evt_cfg_t   i_wr_cfg,
  output logic       o_count_en,
  output logic       o_of_rise,
  output evt_cfg_t   o_cfg
);

  evt_cfg_t r_cfg;
  logic     w_block;
  logic     w_wrap;

  assign w_block    = mode_blocks(i_priv, r_cfg);
  assign o_count_en = i_event & ~i_inhibit & ~i_stop & ~w_block & ~i_freeze;
  assign w_wrap     = o_count_en & i_at_max;
  assign o_of_rise  = w_wrap & ~r_cfg.of;
  assign o_cfg      = r_cfg;

  // A wrap overrides the OF value of a simultaneous software write; filters still take the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg <= '0;
    end else begin
      if (i_wr_en) r_cfg <= i_wr_cfg;
      if (w_wrap)  r_cfg.of <= 1'b1;
    end
  end

endmodule

// File: rtl/hpm_overflow_ctrl.sv
// Performance-counter overflow controller: count gating, sticky OF flags and LCOFI request.
// Optional build macro HPM_FREEZE_ON_OVF_EN freezes all hpm counters while any OF is set.
module hpm_overflow_ctrl
  import hpm_overflow_ctrl_pkg::*;
#(
  parameter int COUNTERS = 32,
  parameter int XLEN     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COUNTERS-1:0] CounterEvent,
  input  logic [COUNTERS-1:0] CounterAtMax,
  input  logic [31:0]         MCOUNTINHIBIT_REGW,
  input  logic                DebugStopCount_REGW,
  input  logic [1:0]          PrivilegeModeW,
  input  logic                EventWriteM,
  input  logic [4:0]          EventIdxM,
  input  logic [XLEN-1:0]     EventWriteValM,
  input  logic                LCOFIClearM,
  output logic [COUNTERS-1:0] CountEnM,
  output logic [31:0]         OverflowM,
  output logic [XLEN-1:0]     EventCfgReadM,
  output logic                LCOFIReqM
);

  evt_cfg_t    w_cfg [0:31];
  evt_cfg_t    w_wr_cfg;
  evt_cfg_t    w_rd_cfg;
  logic [31:0] w_of_bits;
  logic [31:0] w_of_rise;
  logic        w_freeze;
  logic        r_lcofi;
  logic        w_unused_inputs;

  assign w_wr_cfg = '{of:   EventWriteValM[EVT_OF_BIT],
                      minh: EventWriteValM[EVT_MINH_BIT],
                      sinh: EventWriteValM[EVT_SINH_BIT],
                      uinh: EventWriteValM[EVT_UINH_BIT]};
  assign w_unused_inputs = ^{EventWriteValM[EVT_UINH_BIT-1:0], CounterAtMax[HPM_FIRST-1:0]};

`ifdef HPM_FREEZE_ON_OVF_EN
  assign w_freeze = |w_of_bits;
`else
  assign w_freeze = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cnt
      if (gi == 1) begin : g_time
        assign CountEnM[gi]  = 1'b0;
        assign w_cfg[gi]     = '0;
        assign w_of_rise[gi] = 1'b0;
      end else if (gi < HPM_FIRST) begin : g_fixed
        // cycle and instret ignore the mode filter and the overflow freeze.
        assign CountEnM[gi]  = CounterEvent[gi] & ~MCOUNTINHIBIT_REGW[gi] & ~DebugStopCount_REGW;
        assign w_cfg[gi]     = '0;
        assign w_of_rise[gi] = 1'b0;
      end else if (gi < COUNTERS) begin : g_hpm
        hpm_ovf_slice u_slice (
          .clk        (clk),
          .reset      (reset),
          .i_event    (CounterEvent[gi]),
          .i_at_max   (CounterAtMax[gi]),
          .i_inhibit  (MCOUNTINHIBIT_REGW[gi]),
          .i_stop     (DebugStopCount_REGW),
          .i_freeze   (w_freeze),
          .i_priv     (PrivilegeModeW),
          .i_wr_en    (EventWriteM && (EventIdxM == 5'(gi))),
          .i_wr_cfg   (w_wr_cfg),
          .o_count_en (CountEnM[gi]),
          .o_of_rise  (w_of_rise[gi]),
          .o_cfg      (w_cfg[gi])
        );
      end else begin : g_absent
        assign w_cfg[gi]     = '0;
        assign w_of_rise[gi] = 1'b0;
      end
      assign w_of_bits[gi] = w_cfg[gi].of;
    end
  endgenerate

  assign OverflowM     = w_of_bits;
  assign w_rd_cfg      = w_cfg[EventIdxM];
  assign EventCfgReadM = {w_rd_cfg, {(XLEN-4){1'b0}}};
  assign LCOFIReqM     = r_lcofi;

  // Only a rising OF raises the request; a new wrap beats a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lcofi <= 1'b0;
    end else if (|w_of_rise) begin
      r_lcofi <= 1'b1;
    end else if (LCOFIClearM) begin
      r_lcofi <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hpm_overflow_ctrl.sv
// Directed bench for hpm_overflow_ctrl: per-cycle reference model compare plus literal checkpoints.
module tb_hpm_overflow_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ev, atmax, inh;
  logic        dbg, wr, clr;
  logic [1:0]  priv;
  logic [4:0]  idx;
  logic [63:0] wval;
  logic [31:0] CountEnM, OverflowM;
  logic [63:0] EventCfgReadM;
  logic        LCOFIReqM;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  bit m_of [32];
  bit m_minh [32];
  bit m_sinh [32];
  bit m_uinh [32];
  bit m_lcofi;

  hpm_overflow_ctrl #(.COUNTERS(32), .XLEN(64)) dut (
    .clk                 (clk),
    .reset               (rst),
    .CounterEvent        (ev),
    .CounterAtMax        (atmax),
    .MCOUNTINHIBIT_REGW  (inh),
    .DebugStopCount_REGW (dbg),
    .PrivilegeModeW      (priv),
    .EventWriteM         (wr),
    .EventIdxM           (idx),
    .EventWriteValM      (wval),
    .LCOFIClearM         (clr),
    .CountEnM            (CountEnM),
    .OverflowM           (OverflowM),
    .EventCfgReadM       (EventCfgReadM),
    .LCOFIReqM           (LCOFIReqM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit blocked(int i);
    if (priv == 2'd3) return m_minh[i];
    if (priv == 2'd1) return m_sinh[i];
    if (priv == 2'd0) return m_uinh[i];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_en();
    logic [31:0] e;
    bit frz;
    frz = 1'b0;
`ifdef HPM_FREEZE_ON_OVF_EN
    for (int j = 3; j < 32; j++) if (m_of[j]) frz = 1'b1;
`endif
    for (int i = 0; i < 32; i++) begin
      e[i] = ev[i] && !inh[i] && !dbg && (i != 1) && (i < 3 || (!blocked(i) && !frz));
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_ovf();
    logic [31:0] o;
    o = '0;
    for (int i = 3; i < 32; i++) o[i] = m_of[i];
    return o;
  endfunction

  function automatic logic [63:0] exp_read();
    int k;
    k = int'(idx);
    if (k < 3) return 64'd0;
    return {m_of[k], m_minh[k], m_sinh[k], m_uinh[k], 60'd0};
  endfunction

  // Reference state update: applies this cycle's inputs at the clock edge.
  always @(posedge clk) begin
    logic [31:0] en;
    bit rise;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_of[i] = 0; m_minh[i] = 0; m_sinh[i] = 0; m_uinh[i] = 0;
      end
      m_lcofi = 0;
    end else begin
      en   = exp_en();
      rise = 0;
      for (int i = 3; i < 32; i++) begin
        bit sel;
        sel = wr && (int'(idx) == i);
        if (sel) begin
          m_of[i] = wval[63]; m_minh[i] = wval[62]; m_sinh[i] = wval[61]; m_uinh[i] = wval[60];
        end
        if (en[i] && atmax[i]) begin
          if (!m_of[i]) rise = 1;
          m_of[i] = 1;
        end
      end
      if (rise) m_lcofi = 1;
      else if (clr) m_lcofi = 0;
    end
  end

  // Compare process: outputs are checked mid-cycle once inputs have settled.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("CountEnM", 64'(CountEnM), 64'(exp_en()));
      check("OverflowM", 64'(OverflowM), 64'(exp_ovf()));
      check("EventCfgReadM", EventCfgReadM, exp_read());
      check("LCOFIReqM", 64'(LCOFIReqM), 64'(m_lcofi));
    end
  end

  initial begin
    rst = 1; ev = '0; atmax = '0; inh = '0; dbg = 0; priv = 2'd3;
    wr = 0; idx = '0; wval = '0; clr = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;

    rst = 0; ev = '1; #3;
    $display("txn: reset release, all events in M mode");
    check("rst_en", 64'(CountEnM), 64'h0000_0000_FFFF_FFFD);
    check("rst_ovf", 64'(OverflowM), 64'd0);
    check("rst_lcofi", 64'(LCOFIReqM), 64'd0);
    check("rst_read", EventCfgReadM, 64'd0);

    @(negedge clk); wr = 1; idx = 5'd3; wval = 64'h4000_0000_0000_0000;
    $display("txn: write mhpmevent[3] MINH");
    @(negedge clk); wr = 0; #3;
    check("minh_m_en3", 64'(CountEnM[3]), 64'd0);
    @(negedge clk); priv = 2'd1; #3;
    $display("txn: S mode with MINH on counter 3");
    check("minh_s_en3", 64'(CountEnM[3]), 64'd1);

    @(negedge clk); atmax[5] = 1'b1;
    $display("txn: counter 5 wraps");
    @(negedge clk); atmax = '0; idx = 5'd5; #3;
    check("wrap5_ovf", 64'(OverflowM), 64'h20);
    check("wrap5_lcofi", 64'(LCOFIReqM), 64'd1);
    check("wrap5_read", EventCfgReadM, 64'h8000_0000_0000_0000);

    @(negedge clk); clr = 1; wr = 1; idx = 5'd5; wval = '0;
    $display("txn: clear LCOFI and OF[5]");
    @(negedge clk); clr = 0; wr = 0; #3;
    check("clr_lcofi", 64'(LCOFIReqM), 64'd0);
    check("clr_ovf", 64'(OverflowM), 64'd0);

    @(negedge clk); atmax[4] = 1'b1; wr = 1; idx = 5'd4; wval = '0; clr = 1;
    $display("txn: wrap 4 with write 0 and LCOFI clear");
    @(negedge clk); atmax = '0; wr = 0; clr = 0; #3;
    check("race4_ovf", 64'(OverflowM), 64'h10);
    check("race4_lcofi", 64'(LCOFIReqM), 64'd1);

    @(negedge clk); clr = 1; wr = 1; idx = 5'd4; wval = '0;
    @(negedge clk); clr = 0; idx = 5'd7; wval = 64'h8000_0000_0000_0000;
    $display("txn: software OF=1 to idx 7");
    @(negedge clk); wr = 0; #3;
    check("sw7_ovf", 64'(OverflowM), 64'h80);
    check("sw7_lcofi", 64'(LCOFIReqM), 64'd0);
    @(negedge clk); wr = 1; idx = 5'd2; wval = '1;
    $display("txn: write to idx 2 ignored");
    @(negedge clk); wr = 0; #3;
    check("idx2_read", EventCfgReadM, 64'd0);
    check("idx2_ovf", 64'(OverflowM), 64'h80);
    @(negedge clk); wr = 1; idx = 5'd7; wval = '0;

    @(negedge clk); wr = 1; idx = 5'd8; wval = 64'h7000_0000_0000_0000;
    $display("txn: all filters on counter 8, reserved mode");
    @(negedge clk); wr = 0; priv = 2'd2; #3;
    check("mode2_en8", 64'(CountEnM[8]), 64'd1);
    @(negedge clk); priv = 2'd0; #3;
    check("modeu_en8", 64'(CountEnM[8]), 64'd0);

    @(negedge clk); priv = 2'd3; dbg = 1; #3;
    $display("txn: debug stop");
    check("dbg_en", 64'(CountEnM), 64'd0);
    @(negedge clk); dbg = 0; inh = 32'h5; #3;
    $display("txn: inhibit cycle and instret");
    check("inh_en", 64'(CountEnM), 64'hFFFF_FEF0);
    @(negedge clk); inh = '0;

    @(negedge clk); wr = 1; idx = 5'd6; wval = 64'h8000_0000_0000_0000;
    $display("txn: set OF[6] by write");
    @(negedge clk); wr = 1; idx = 5'd6; wval = '0; #3;
`ifdef HPM_FREEZE_ON_OVF_EN
    check("frz_en", 64'(CountEnM), 64'h5);
`else
    check("nofrz_en", 64'(CountEnM), 64'hFFFF_FEF5);
`endif
    @(negedge clk); wr = 0; #3;
    check("resume_en", 64'(CountEnM), 64'hFFFF_FEF5);

    @(negedge clk); priv = 2'd1; atmax = 32'hFFFF_FFF8;
    $display("txn: all hpm counters at max in S mode");
    @(negedge clk); atmax = '0; #3;
    check("multi_ovf", 64'(OverflowM), 64'hFFFF_FEF8);
    check("multi_lcofi", 64'(LCOFIReqM), 64'd1);

    @(negedge clk); rst = 1; wr = 1; idx = 5'd9; wval = 64'hF000_0000_0000_0000; atmax = '1;
    $display("txn: reset with pending write and wraps");
    @(negedge clk); rst = 0; wr = 0; atmax = '0; #3;
    check("mrst_ovf", 64'(OverflowM), 64'd0);
    check("mrst_lcofi", 64'(LCOFIReqM), 64'd0);
    check("mrst_read", EventCfgReadM, 64'd0);

    repeat (2) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
